// File: rtl/iterative_shift_unit.sv
// rtl/iterative_shift_unit.sv - multi-cycle SLL/SRL/SRA shift unit for the EX stage
//
// Replaces a combinational barrel shifter with a 1-bit (or, with
// ITER_SHIFT_FAST4_EN defined, a 4-bit) shift step iterated by a small FSM.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   shift request, accepted only while idle
//   flush   synchronous abort; wins over start and over completion
//   op      00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   a       operand (rs1)
//   shamt   shift amount, 0..N-1
//   busy    high whenever the unit is not idle
//   done    one-cycle pulse when result is first valid
//   result  shifted value, held until the next completion
//
// Optional feature macro: ITER_SHIFT_FAST4_EN (4-bit steps while cnt >= 4).

module iterative_shift_unit #(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic [1:0]    op,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t        state, state_nxt;
  logic [N-1:0]  acc, acc_nxt;
  logic [SW-1:0] cnt, cnt_nxt;
  logic [1:0]    op_q, op_q_nxt;
  logic [N-1:0]  result_nxt;

  // One shift step on acc according to the latched op.
  logic [N-1:0]  acc_step;
  logic [SW-1:0] cnt_step;

  always_comb begin
    acc_step = acc;
    cnt_step = cnt - SW'(1);
`ifdef ITER_SHIFT_FAST4_EN
    if (cnt >= SW'(4)) begin
      cnt_step = cnt - SW'(4);
      case (op_q)
        OP_SLL:  acc_step = {acc[N-5:0], 4'b0000};
        OP_SRL:  acc_step = {4'b0000, acc[N-1:4]};
        OP_SRA:  acc_step = {{4{acc[N-1]}}, acc[N-1:4]};
        default: acc_step = acc;
      endcase
    end else begin
      case (op_q)
        OP_SLL:  acc_step = {acc[N-2:0], 1'b0};
        OP_SRL:  acc_step = {1'b0, acc[N-1:1]};
        OP_SRA:  acc_step = {acc[N-1], acc[N-1:1]};
        default: acc_step = acc;
      endcase
    end
`else
    case (op_q)
      OP_SLL:  acc_step = {acc[N-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc[N-1:1]};
      OP_SRA:  acc_step = {acc[N-1], acc[N-1:1]};
      default: acc_step = acc;
    endcase
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    op_q_nxt   = op_q;
    result_nxt = result;

    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt   = a;
          // Pass-through is a zero-length shift regardless of shamt.
          cnt_nxt   = (op == OP_PASS) ? '0 : shamt;
          op_q_nxt  = op;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          result_nxt = acc;
          state_nxt  = S_DONE;
        end else begin
          acc_nxt = acc_step;
          cnt_nxt = cnt_step;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // A squash abandons the op in flight and must not publish its result.
    if (flush) begin
      state_nxt  = S_IDLE;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      op_q_nxt   = op_q;
      result_nxt = result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      cnt    <= cnt_nxt;
      op_q   <= op_q_nxt;
      result <= result_nxt;
    end
  end

  assign busy = (state != S_IDLE);
  // A flush arriving in the DONE cycle suppresses the pulse as well.
  assign done = (state == S_DONE) && !flush;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// tb/tb_iterative_shift_unit.sv - self-checking bench for iterative_shift_unit

module tb_iterative_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [4:0]  shamt_i;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  iterative_shift_unit #(.N(32), .SW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op_i),
    .a      (a_i),
    .shamt  (shamt_i),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: result by plain shift operators, busy time by cycle count.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] x, input logic [4:0] s);
    case (o)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return 32'($signed(x) >>> s);
      default: return x;
    endcase
  endfunction

  function automatic int shift_cycles(input logic [1:0] o, input logic [4:0] s);
    int e;
    e = (o == 2'b11) ? 0 : int'(s);
`ifdef ITER_SHIFT_FAST4_EN
    return e / 4 + e % 4;
`else
    return e;
`endif
  endfunction

  // m_left: edges still to go before the done cycle; 0 while in the done cycle.
  logic        m_busy;
  int          m_left;
  logic [31:0] m_pend;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_left <= shift_cycles(op_i, shamt_i) + 1;
        m_pend <= ref_shift(op_i, a_i, shamt_i);
      end
    end else if (m_left == 0) begin
      m_busy <= 1'b0;
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) m_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_busy && m_left == 0 && !flush});
      check("result", result, m_res);
    end
  end

  // Issue one op; optionally pulse start (with other operands) or flush mid-op.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                        input logic [4:0] s, input logic [31:0] exp_res, input int exp_lat,
                        input int pulse_at, input int flush_at);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(posedge clk); #1;
    op_i = o; a_i = x; shamt_i = s; start = 1'b1; flush = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      n++;
      start = (n == pulse_at);
      flush = (n == flush_at);
      if (n == pulse_at) begin
        a_i = ~x;
        shamt_i = s ^ 5'd1;
      end
      @(negedge clk);
      if (flush_at > 0 && n == flush_at + 1)
        check({nm, "_busy_after_flush"}, {31'b0, busy}, 32'd0);
      if (done) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    flush = 1'b0;
    if (flush_at == 0) begin
      check({nm, "_done_seen"}, {31'b0, got}, 32'd1);
      check({nm, "_latency"}, n, exp_lat);
    end else begin
      check({nm, "_no_done"}, {31'b0, got}, 32'd0);
    end
    check({nm, "_result"}, result, exp_res);
  endtask

`ifdef ITER_SHIFT_FAST4_EN
  localparam int LAT31 = 12;
  localparam int LAT4  = 3;
  localparam int LAT9  = 5;
`else
  localparam int LAT31 = 33;
  localparam int LAT4  = 6;
  localparam int LAT9  = 11;
`endif

  initial begin
    bit seen;
    rst = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op_i = 2'b00;
    a_i = '0;
    shamt_i = '0;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, LAT31, 0, 0);
    run_op("sra4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, LAT4, 0, 0);
    run_op("srl4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, LAT4, 0, 0);
    run_op("sra0",  2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 2, 0, 0);
    run_op("pass7", 2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678, 2, 0, 0);
    run_op("srl9",  2'b01, 32'hFFFF_0000, 5'd9,  32'h007F_FF80, LAT9, 0, 0);
    run_op("busy_start", 2'b00, 32'h0000_00F0, 5'd8, 32'h0000_F000, 10 - (LAT9 == 5 ? 8 - 2 : 0), 3, 0);
    run_op("flush3", 2'b00, 32'h0000_0001, 5'd10, 32'h0000_F000, 0, 0, 3);

    // Asynchronous reset in the middle of an SLL by 20.
    @(posedge clk); #1;
    op_i = 2'b00; a_i = 32'h0000_0003; shamt_i = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midreset_no_done", {31'b0, seen}, 32'd0);

    // Random traffic, including start during busy and sporadic flushes.
    repeat (3000) begin
      @(posedge clk); #1;
      start   = ($urandom % 3) == 0;
      flush   = ($urandom % 40) == 0;
      op_i    = 2'($urandom);
      a_i     = $urandom;
      shamt_i = 5'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
